iram_ctrl: RTL

Controller that owns both ports of the 256x8 instruction RAM and shares them between the stack-machine fetch unit and a byte-stream program loader (UART side). It sequences a program load (write N bytes from address 0), verifies the load by reading it back against a host-supplied checksum, and only then releases the CPU. It sits between the loader/fetch logic and the `iram` instance; the CPU never drives the RAM directly.

---
 rtl/iram_ctrl_pkg.sv | 27 ++
 rtl/iram_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/iram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : iram_ctrl_pkg
// Purpose  : Shared widths, controller state encoding and load-length decode
//            for the instruction-RAM controller.
// Revision : 1.0 - initial release
// ============================================================================
package iram_ctrl_pkg;

   localparam int IRAM_AW = 8;
   localparam int IRAM_DW = 8;

   // Controller states; plain constants keep the encoding visible in waves.
   typedef logic [2:0] state_t;
   localparam state_t ST_HALT   = 3'd0;
   localparam state_t ST_RUN    = 3'd1;
   localparam state_t ST_LOAD   = 3'd2;
   localparam state_t ST_CKSUM  = 3'd3;
   localparam state_t ST_VERIFY = 3'd4;

   // A length byte of zero stands for a full 256-byte image.
   function automatic logic [IRAM_AW:0] decode_len(input logic [IRAM_AW-1:0] len);
      return (len == '0) ? {1'b1, {IRAM_AW{1'b0}}} : {1'b0, len};
   endfunction

endpackage : iram_ctrl_pkg
`default_nettype wire

// File: rtl/iram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : iram_ctrl
// Purpose  : Owns both ports of the 256x8 instruction RAM. Arbitrates between
//            CPU instruction fetch and a byte-stream program loader, verifies
//            a freshly loaded image against a host checksum before letting
//            the CPU run.
// Revision : 1.0 - initial release
// ============================================================================
module iram_ctrl
   import iram_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   // fetch side
   input  logic [IRAM_AW-1:0] cpu_pc,
   input  logic               cpu_fetch,
   output logic [IRAM_DW-1:0] cpu_inst,
   output logic               cpu_inst_vld,
   output logic               cpu_stall,
   output logic               cpu_start,
   // loader side
   input  logic               run_req,
   input  logic               ld_start,
   input  logic [IRAM_AW-1:0] ld_len,
   input  logic               ld_valid,
   input  logic [IRAM_DW-1:0] ld_data,
   output logic               ld_ready,
   output logic               ld_done,
   output logic               ld_err,
   // RAM ports
   output logic [IRAM_AW-1:0] ram_radr,
   input  logic [IRAM_DW-1:0] ram_rdata,
   output logic [IRAM_AW-1:0] ram_wadr,
   output logic [IRAM_DW-1:0] ram_wdata,
   output logic               ram_wen
);

   state_t             state;
   logic [IRAM_AW-1:0] wptr;       // next write address during LOAD
   logic [IRAM_AW:0]   remain;     // bytes still to be written
   logic [IRAM_AW:0]   len;        // decoded image length, reused by VERIFY
   logic [IRAM_DW-1:0] host_sum;   // checksum supplied by the host
   logic [IRAM_AW:0]   vcnt;       // VERIFY cycle index: read address and data lag
   logic [IRAM_DW-1:0] vsum;       // running sum of read-back bytes

   logic               xfer;
   logic               accept_start;
   logic [IRAM_DW-1:0] sum_next;

   assign cpu_inst     = ram_rdata;
   assign cpu_stall    = (state != ST_RUN);
   assign xfer         = ld_valid & ld_ready;
   assign accept_start = ld_start & ((state == ST_HALT) | (state == ST_RUN));
   assign sum_next     = vsum + ram_rdata;

   // Combinational RAM port steering and loader handshake.
   always_comb begin
      ld_ready  = (state == ST_LOAD) | (state == ST_CKSUM);
      ram_wen   = (state == ST_LOAD) & ld_valid;
      ram_wadr  = wptr;
      ram_wdata = ld_data;
      ram_radr  = '0;
      if (state == ST_RUN)
         ram_radr = cpu_pc;
      else if (state == ST_VERIFY)
         ram_radr = vcnt[IRAM_AW-1:0];
   end

   // Main sequencer: state transitions, pointers, checksum and status pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_HALT;
         wptr         <= '0;
         remain       <= '0;
         len          <= '0;
         host_sum     <= '0;
         vcnt         <= '0;
         vsum         <= '0;
         cpu_inst_vld <= 1'b0;
         cpu_start    <= 1'b0;
         ld_done      <= 1'b0;
         ld_err       <= 1'b0;
      end else begin
         cpu_start    <= 1'b0;
         ld_done      <= 1'b0;
         // A fetch issued in the last RUN cycle still completes.
         cpu_inst_vld <= (state == ST_RUN) & cpu_fetch;

         if (accept_start) begin
            state  <= ST_LOAD;
            len    <= decode_len(ld_len);
            remain <= decode_len(ld_len);
            wptr   <= '0;
            ld_err <= 1'b0;
         end else begin
            case (state)
               ST_HALT: begin
                  if (run_req) begin
                     state     <= ST_RUN;
                     cpu_start <= 1'b1;
                  end
               end
               ST_RUN: ;
               ST_LOAD: begin
                  if (xfer) begin
                     wptr   <= wptr + 1'b1;
                     remain <= remain - 1'b1;
                     if (remain == 9'd1)
                        state <= ST_CKSUM;
                  end
               end
               ST_CKSUM: begin
                  if (xfer) begin
                     host_sum <= ld_data;
                     vcnt     <= '0;
                     vsum     <= '0;
                     state    <= ST_VERIFY;
                  end
               end
               ST_VERIFY: begin
                  // Read data trails the address by one cycle, so summing
                  // starts at index 1 and ends at index len.
                  if (vcnt != '0)
                     vsum <= sum_next;
                  if (vcnt == len) begin
                     if (sum_next == host_sum) begin
                        state     <= ST_RUN;
                        cpu_start <= 1'b1;
                        ld_done   <= 1'b1;
                     end else begin
                        state  <= ST_HALT;
                        ld_err <= 1'b1;
                     end
                  end else begin
                     vcnt <= vcnt + 1'b1;
                  end
               end
               default: state <= ST_HALT;
            endcase
         end
      end
   end

endmodule : iram_ctrl
`default_nettype wire
